// File: rtl/fetch_sequencer_if.sv
// Fetch/decode/memory signal bundle for fetch_sequencer.
// master = the sequencer; slave = memory, decode and execute around it.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 29
);
  logic               in_start;
  logic [INSTR_W-1:0] in_instruction;
  logic [ADDR_W-1:0]  out_add;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_valid;
  logic               in_ready;
  logic               in_redirect;
  logic [ADDR_W-1:0]  in_redirect_add;
  logic               out_halted;
  logic [1:0]         out_state;

  modport master (
    input  in_start, in_instruction, in_ready, in_redirect, in_redirect_add,
    output out_add, out_instruction, out_pc, out_valid, out_halted, out_state
  );

  modport slave (
    output in_start, in_instruction, in_ready, in_redirect, in_redirect_add,
    input  out_add, out_instruction, out_pc, out_valid, out_halted, out_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills a one-entry IR for decode.
// Define FETCH_JUMP_FOLD_EN to fold unconditional jumps inside fetch.
//
// state  | meaning
// IDLE   | out of reset, no fetching; redirect only loads the PC
// FETCH  | fetching one instruction per free slot
// HALTED | halt issued; no fetching, pending IR drains
module fetch_sequencer #(
  parameter int               ADDR_W     = 8,
  parameter int               INSTR_W    = 29,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(1),
  parameter logic [4:0]       OP_JUMP    = 5'b01001,
  parameter logic [4:0]       OP_HALT    = 5'b11111
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  fetch_sequencer_if.master  bus
);

`ifdef FETCH_JUMP_FOLD_EN
  localparam bit FOLD_EN = 1'b1;
`else
  localparam bit FOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  ir_pc;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;

  logic [4:0]         opcode;
  logic [ADDR_W-1:0]  jump_target;
  logic               slot_free;
  logic               is_halt;
  logic               is_fold;

  assign opcode      = bus.in_instruction[INSTR_W-1 -: 5];
  assign jump_target = bus.in_instruction[23 -: ADDR_W];
  assign slot_free   = !ir_valid || bus.in_ready;
  assign is_halt     = (opcode == OP_HALT);
  assign is_fold     = FOLD_EN && (opcode == OP_JUMP);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_ready) ir_valid <= 1'b0;
          if (bus.in_redirect) pc <= bus.in_redirect_add;
          else if (bus.in_start) state <= FETCH;
        end
        FETCH: begin
          if (bus.in_redirect) begin
            pc       <= bus.in_redirect_add;
            ir_valid <= 1'b0;
          end else if (slot_free) begin
            if (is_fold) begin
              // jump consumed here; the slot goes empty for one cycle
              pc       <= jump_target;
              ir_valid <= 1'b0;
            end else begin
              ir       <= bus.in_instruction;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              pc       <= pc + ADDR_W'(1);
              if (is_halt) state <= HALTED;
            end
          end
        end
        HALTED: begin
          if (bus.in_redirect) begin
            pc       <= bus.in_redirect_add;
            ir_valid <= 1'b0;
            state    <= FETCH;
          end else begin
            if (bus.in_ready) ir_valid <= 1'b0;
            if (bus.in_start) state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_add         = pc;
  assign bus.out_instruction = ir;
  assign bus.out_pc          = ir_pc;
  assign bus.out_valid       = ir_valid;
  assign bus.out_halted      = (state == HALTED);
  assign bus.out_state       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: issued PCs are scoreboarded in order,
// state/stall/flush/halt/reset behaviour is checked at fixed points.
module tb_fetch_sequencer;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 29;
  localparam logic [4:0] OP_JUMP = 5'b01001;
  localparam logic [4:0] OP_HALT = 5'b11111;

`ifdef FETCH_JUMP_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  logic [INSTR_W-1:0] mem [256];
  assign bus.in_instruction = mem[bus.out_add];

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transfers are sampled on the falling edge, inputs change 1 ns after the rising edge.
  task automatic tick();
    logic [ADDR_W-1:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.in_ready) begin
      chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", 32'(bus.out_pc), 32'(e));
        chk("xfer_instr", 32'(bus.out_instruction), 32'(mem[e]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
    chk("drain_budget", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  32'(bus.out_valid),       32'd0);
    chk({tag, "_add"},    32'(bus.out_add),         32'd1);
    chk({tag, "_state"},  32'(bus.out_state),       32'd0);
    chk({tag, "_halted"}, 32'(bus.out_halted),      32'd0);
    chk({tag, "_pc"},     32'(bus.out_pc),          32'd0);
    chk({tag, "_instr"},  32'(bus.out_instruction), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {5'h02, a[7:0], 16'h0000};
    mem[0]     = '0;
    mem[1]     = {5'h03, 8'h01, 8'h08, 8'h01};
    mem[2]     = {5'h01, 8'h02, 8'h01, 8'h02};
    mem[3]     = {5'h03, 8'h03, 8'h02, 8'h05};
    mem[4]     = {5'h04, 8'h01, 8'h03, 8'h01};
    mem[5]     = {OP_JUMP, 8'h01, 16'h0000};
    mem[8'h10] = {OP_HALT, 24'h000000};
    mem[8'hFF] = {5'h03, 8'hFF, 8'h01, 8'h01};

    bus.in_start        = 1'b0;
    bus.in_ready        = 1'b1;
    bus.in_redirect     = 1'b0;
    bus.in_redirect_add = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("por");
    #3 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_state", 32'(bus.out_state), 32'd0);
    end

    // start latency and straight-line fetch
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    chk("start_state", 32'(bus.out_state), 32'd1);
    chk("start_valid", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    drain(10);
    chk("seq_pc4", 32'(bus.out_pc), 32'd4);
    exp_q.push_back(8'd4);
    drain(5);
    chk("jump_valid", 32'(bus.out_valid), FOLD ? 32'd0 : 32'd1);
    chk("jump_add",   32'(bus.out_add),   FOLD ? 32'd1 : 32'd6);

`ifdef FETCH_JUMP_FOLD_EN
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    drain(10);
`else
    exp_q.push_back(8'd5); exp_q.push_back(8'd6);
    drain(10);
    chk("nofold_pc7", 32'(bus.out_pc), 32'd7);
    bus.in_ready = 1'b0; bus.in_redirect = 1'b1; bus.in_redirect_add = 8'd1;
    tick();
    bus.in_ready = 1'b1; bus.in_redirect = 1'b0;
    chk("nofold_flush", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    drain(10);
`endif

    // stall with out_pc = 3
    chk("pre_stall_pc", 32'(bus.out_pc), 32'd3);
    bus.in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    32'(bus.out_pc),          32'd3);
      chk("stall_valid", 32'(bus.out_valid),       32'd1);
      chk("stall_add",   32'(bus.out_add),         32'd4);
      chk("stall_instr", 32'(bus.out_instruction), 32'(mem[3]));
    end
    bus.in_ready = 1'b1;
    exp_q.push_back(8'd3);
    drain(5);
    chk("release_pc",  32'(bus.out_pc),  32'd4);
    chk("release_add", 32'(bus.out_add), 32'd5);

    // redirect while stalled, jump on the memory bus
    bus.in_ready = 1'b0; bus.in_redirect = 1'b1; bus.in_redirect_add = 8'h40;
    tick();
    bus.in_ready = 1'b1; bus.in_redirect = 1'b0;
    chk("redir_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_add",   32'(bus.out_add),   32'h40);
    chk("redir_state", 32'(bus.out_state), 32'd1);
    tick();
    chk("redir_pc",    32'(bus.out_pc),    32'h40);
    chk("redir_valid2", 32'(bus.out_valid), 32'd1);
    exp_q.push_back(8'h40);
    drain(5);

    // wrap through 0xFF
    exp_q.push_back(8'h41);
    bus.in_redirect = 1'b1; bus.in_redirect_add = 8'hFF;
    tick();
    bus.in_redirect = 1'b0;
    chk("wrap_flush", 32'(bus.out_valid), 32'd0);
    tick();
    chk("wrap_pc",    32'(bus.out_pc),          32'hFF);
    chk("wrap_valid", 32'(bus.out_valid),       32'd1);
    chk("wrap_add",   32'(bus.out_add),         32'h00);
    chk("wrap_instr", 32'(bus.out_instruction), 32'(mem[8'hFF]));
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    drain(6);
    chk("wrap_next", 32'(bus.out_pc), 32'd1);

    // halt at 0x10
    exp_q.push_back(8'd1);
    bus.in_redirect = 1'b1; bus.in_redirect_add = 8'h10;
    tick();
    bus.in_redirect = 1'b0;
    tick();
    chk("halt_pc",     32'(bus.out_pc),     32'h10);
    chk("halt_flag",   32'(bus.out_halted), 32'd1);
    chk("halt_add",    32'(bus.out_add),    32'h11);
    chk("halt_state",  32'(bus.out_state),  32'd2);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_frozen", 32'({bus.out_halted, bus.out_valid, bus.out_add}), 32'({1'b1, 1'b0, 8'h11}));
    end
    chk("halt_drained", 32'(exp_q.size()), 32'd0);
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    chk("resume_state", 32'(bus.out_state), 32'd1);
    exp_q.push_back(8'h11);
    drain(5);
    chk("resume_next", 32'(bus.out_pc), 32'h12);

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_valid", 32'(bus.out_valid), 32'd0);
      chk("postrst_state", 32'(bus.out_state), 32'd0);
    end
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    for (int p = 1; p <= 4; p++) exp_q.push_back(ADDR_W'(p));
    drain(10);
    chk("rerun_jump_valid", 32'(bus.out_valid), FOLD ? 32'd0 : 32'd1);
    chk("rerun_jump_add",   32'(bus.out_add),   FOLD ? 32'd1 : 32'd6);
`ifdef FETCH_JUMP_FOLD_EN
    exp_q.push_back(8'd1);
    drain(5);
`else
    exp_q.push_back(8'd5); exp_q.push_back(8'd6);
    drain(6);
    chk("rerun_pc7", 32'(bus.out_pc), 32'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the combinational program memory. Owns the program counter, drives the memory read address, and captures each 29-bit instruction into a one-entry instruction register. Presents that register to the decode stage with a valid/ready handshake. Folds unconditional jumps, honours halt, and accepts redirects from execute.

## Interface
- `ADDR_W`, 8: program counter and memory address width.
- `INSTR_W`, 29: instruction width, formatted as opcode[28:24], field A[23:16], field B[15:8], field C[7:0].
- `RESET_ADDR`, 1: PC value after reset. Address 0 holds the null word.
- `OP_JUMP`, 5'b01001: jump opcode. The target is field A.
- `OP_HALT`, 5'b11111: halt opcode.
- `in_clk`  in  1  sole clock; all state changes on its rising edge.
- `in_rst_n`  in  1  asynchronous, active-low reset.
- `in_start`  in  1  one-cycle pulse; leaves IDLE or HALTED.
- `in_instruction`  in  INSTR_W  memory read data for `out_add`, valid in the same cycle.
- `out_add`  out  ADDR_W  memory read address, equal to the PC register.
- `out_instruction`  out  INSTR_W  instruction register.
- `out_pc`  out  ADDR_W  address from which `out_instruction` was fetched.
- `out_valid`  out  1  instruction register holds an instruction for decode.
- `in_ready`  in  1  decode accepts; a transfer occurs when `out_valid` and `in_ready` are both 1.
- `in_redirect`  in  1  execute-stage branch/redirect request.
- `in_redirect_add`  in  ADDR_W  redirect target.
- `out_halted`  out  1  high while in HALTED.
- `out_state`  out  2  state encoding: IDLE=00, FETCH=01, HALTED=10.

## Operation
- Reset values:
  - PC = `RESET_ADDR`
  - `out_instruction` = 0, `out_pc` = 0
  - `out_valid` = 0, `out_halted` = 0
  - state = IDLE
- IDLE:
  - No fetch occurs.
  - `in_start` moves to FETCH.
  - `in_redirect` loads the PC and stays in IDLE.
- FETCH: the slot is free when `out_valid` = 0 or `in_ready` = 1. On a free slot:
  - IR ← `in_instruction`, `out_pc` ← PC, `out_valid` ← 1, PC ← PC+1.
  - PC arithmetic is modulo 2^ADDR_W, so 255 wraps to 0.
- Stall: slot not free (`out_valid` = 1, `in_ready` = 0).
  - PC, IR, `out_pc` and `out_valid` all hold.
- Consumed without refill: `out_valid` ← 0. This occurs only on fold, redirect, or a state other than FETCH.
- Halt: a fetched `OP_HALT` is loaded and issued like any instruction.
  - State ← HALTED and PC ← halt address + 1 in the same edge.
  - HALTED does no fetching, and a pending IR still drains normally.
  - `in_start` returns to FETCH.
- Redirect: `in_redirect` in FETCH or HALTED does the following:
  - PC ← `in_redirect_add`, `out_valid` ← 0 (flush, even when stalled), state ← FETCH.
  - Priority is reset > redirect > halt/fold > stall > normal fetch.
- `in_start` in FETCH is ignored.

## Timing
- `out_add` is registered, so the memory output is sampled in the cycle it is addressed.
- Start latency:
  - `in_start` is sampled at edge n and the state is FETCH from n.
  - The first instruction is captured at edge n+1.
  - `out_valid` = 1 from edge n+1, two edges after the start pulse was asserted.
- Throughput is one instruction per cycle with `in_ready` held at 1.
- Folded jump costs one bubble cycle with `out_valid` = 0.
- Redirect to first valid: one cycle. Target captured at the next edge.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately, without waiting for a clock.
  - After deassertion, the block stays in IDLE until `in_start`.

## Configuration
- `FETCH_JUMP_FOLD_EN` defined:
  - A fetched `OP_JUMP` is consumed in fetch and never issued.
  - PC ← field A and `out_valid` ← 0 for that cycle.
- `FETCH_JUMP_FOLD_EN` undefined:
  - `OP_JUMP` is issued like any instruction and PC increments.
  - Decode/execute must use `in_redirect` to change flow.

## Test plan
1. Fold enabled, memory loaded as follows, start with `in_ready` = 1:
   - Contents: 1=0x0A0_8101-style `addi`, 2 `add`, 3 `addi`, 4 `subi`, 5=`jump 1`.
   - Required `out_pc` sequence on valid cycles: 1, 2, 3, 4, one bubble, 1, 2, … . `out_pc` = 5 never appears.
2. Stall: hold `in_ready` = 0 for 3 cycles while `out_pc` = 3.
   - `out_instruction`, `out_pc` = 3, `out_valid` = 1 and `out_add` = 4 stay stable.
   - The release cycle transfers 3 and the next `out_pc` is 4.
3. Assert `in_redirect` with `in_redirect_add` = 0x40 during a stall in the same cycle a jump is fetched.
   - Next cycle: `out_valid` = 0, `out_add` = 0x40.
   - Following cycle: `out_pc` = 0x40, `out_valid` = 1.
4. Wrap: redirect to 0xFF, which holds a non-jump.
   - Instruction 0xFF is issued, then `out_add` = 0x00 and the next `out_pc` = 0x00.
5. Halt at 0x10:
   - It is issued with `out_pc` = 0x10, then `out_halted` = 1 and `out_add` = 0x11 frozen for 10 cycles.
   - `in_start` resumes with next `out_pc` = 0x11.
6. Reset pulse between clock edges mid-stream:
   - `out_valid` = 0, `out_add` = 1 and `out_state` = 00 without waiting for a clock edge.
   - No valid output until `in_start`.
   - With fold undefined, repeat scenario 1: `out_pc` = 5 is issued, then 6 follows unless a redirect is applied.
